// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared constants and types for the NTT stage sequencer and its address generator.
package ntt_pkg;
  localparam int N          = 256;
  localparam int LOG_N      = $clog2(N);
  localparam int AW         = LOG_N;
  localparam int Q          = 40961;
  localparam int W          = $clog2(Q);
  localparam int NTT_WB_LAT = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ntt_state_t;
endpackage

// File: rtl/ntt_stage_ctrl_addr_gen.sv
// Cooley-Tukey DIT addressing: maps (stage s, pair j) to operand addresses A/B and twiddle index.
// Purely combinational; zero latency, no flow control.
module ntt_addr_gen #(
  parameter int LOG_N = 8,
  parameter int AW    = LOG_N,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG_N-2:0] j,
  output logic [AW-1:0]    a,
  output logic [AW-1:0]    b,
  output logic [LOG_N-2:0] tw
);
  import ntt_pkg::*;

  logic [AW-1:0] len;
  logic [AW-1:0] jx;
  logic [AW-1:0] k;

  always_comb begin
    len = AW'(1) << s;
    jx  = AW'(j);
    k   = jx & (len - AW'(1));
    // Group index (j>>s) spaced by 2*len, offset by position k within the group.
    a   = (((jx >> s) << s) << 1) | k;
    b   = a + len;
    tw  = (LOG_N-1)'(k << (LOG_N - 1 - int'(s)));
  end
endmodule

// File: rtl/ntt_stage_ctrl.sv
// Sequences an in-place radix-2 NTT/iNTT: one butterfly per cycle, two bubble cycles per stage,
// write-back addresses are the read addresses delayed by the RAM + butterfly latency.
module ntt_stage_ctrl #(
  parameter int N     = ntt_pkg::N,
  parameter int LOG_N = $clog2(N),
  parameter int AW    = LOG_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             intt_req,
  output logic             busy,
  output logic             done,
  output logic             iNTT_mode,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b
);
  import ntt_pkg::*;

  localparam int            SW     = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int            JW     = LOG_N - 1;
  localparam logic [JW-1:0] J_LAST = JW'(N/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

  ntt_state_t    state;
  logic [SW-1:0] s;
  logic [JW-1:0] j;
  logic [1:0]    dcnt;
  logic          last_stage;

  logic [AW-1:0] gen_a;
  logic [AW-1:0] gen_b;
  logic [JW-1:0] gen_tw;

  logic          en_d1;
  logic [AW-1:0] a_d1;
  logic [AW-1:0] b_d1;

  ntt_addr_gen #(
    .LOG_N (LOG_N),
    .AW    (AW),
    .SW    (SW)
  ) u_addr_gen (
    .s  (s),
    .j  (j),
    .a  (gen_a),
    .b  (gen_b),
    .tw (gen_tw)
  );

  // Outputs are registered, so (s, j) always names the pair to be issued at the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      j          <= '0;
      dcnt       <= '0;
      last_stage <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iNTT_mode  <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      tw_addr    <= '0;
      en_d1      <= 1'b0;
      a_d1       <= '0;
      b_d1       <= '0;
      wr_en      <= 1'b0;
      wr_addr_a  <= '0;
      wr_addr_b  <= '0;
    end else begin
      en_d1     <= rd_en;
      a_d1      <= rd_addr_a;
      b_d1      <= rd_addr_b;
      wr_en     <= en_d1;
      wr_addr_a <= a_d1;
      wr_addr_b <= b_d1;

      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      done      <= 1'b0;

      unique case (state)
        IDLE: begin
          // s and j are already zero here, so the generator is presenting pair (0, 0).
          if (start) begin
            iNTT_mode <= intt_req;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a;
            rd_addr_b <= gen_b;
            tw_addr   <= gen_tw;
            j         <= j + 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          rd_en     <= 1'b1;
          rd_addr_a <= gen_a;
          rd_addr_b <= gen_b;
          tw_addr   <= gen_tw;
          if (j == J_LAST) begin
            j     <= '0;
            dcnt  <= '0;
            state <= DRAIN;
            if (s == S_LAST) begin
              s          <= '0;
              last_stage <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end

        DRAIN: begin
          // First DRAIN cycle still shows the last registered read; two idle cycles follow.
          if (dcnt == 2'(NTT_WB_LAT)) begin
            if (last_stage) begin
              last_stage <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              rd_en     <= 1'b1;
              rd_addr_a <= gen_a;
              rd_addr_b <= gen_b;
              tw_addr   <= gen_tw;
              j         <= j + 1'b1;
              state     <= RUN;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
